// File: rtl/bus_pkg.sv
// Shared definitions for the master-side serial bus port.
// Default bus geometry and the controller state encoding.
package bus_pkg;

  localparam int SID_W_DEF       = 2;
  localparam int ADDR_W_DEF      = 12;
  localparam int DATA_W_DEF      = 8;
  localparam int ACK_TIMEOUT_DEF = 8;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    REQ        = 4'd1,
    ADDR       = 4'd2,
    ACK_WAIT   = 4'd3,
    WDATA      = 4'd4,
    RWAIT      = 4'd5,
    RDATA      = 4'd6,
    SPLIT_WAIT = 4'd7,
    DONE       = 4'd8
  } state_t;

endpackage

// File: rtl/bus_shift_reg.sv
// Generic right-shifting register: parallel load has priority over shift.
// Serial-in enters at the MSB, serial-out is the LSB; one cycle per operation.
module bus_shift_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         i_load,
  input  logic [W-1:0] i_load_dat,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic [W-1:0] o_q,
  output logic         o_sout
);

  logic [W-1:0] r_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)        r_q <= '0;
    else if (i_load)  r_q <= i_load_dat;
    else if (i_shift) r_q <= {i_sin, r_q[W-1:1]};
  end

  assign o_q    = r_q;
  assign o_sout = r_q[0];

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: request/grant, serial address+data out, serial read in,
// split/resume and grant-loss handling. All outputs registered.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int SID_W       = SID_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              M_START,
  input  logic              M_RW,
  input  logic [SID_W-1:0]  M_SLAVE,
  input  logic [ADDR_W-1:0] M_ADDR,
  input  logic [DATA_W-1:0] M_WDATA,
  output logic              M_BUSY,
  output logic              M_DONE,
  output logic              M_ERR,
  output logic [DATA_W-1:0] M_RDATA,
  output logic              B_REQ,
  input  logic              B_GRANT,
  output logic              B_UTIL,
  output logic              B_MODE,
  output logic              B_VALID,
  output logic              B_WDATA,
  input  logic              B_ACK,
  input  logic              B_RVALID,
  input  logic              B_RDATA,
  input  logic              B_SPLIT,
  input  logic              B_SPL_RESUME
);

  localparam int AW    = SID_W + ADDR_W;
  localparam int PW    = AW + DATA_W;
  localparam int CNT_W = $clog2(AW + DATA_W + ACK_TIMEOUT + 1);

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_rw, w_rw;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic              r_req, w_req;
  logic              r_util, w_util;
  logic              r_mode, w_mode;
  logic              r_valid, w_valid;
  logic              r_wbit, w_wbit;

  logic              w_piso_load, w_piso_shift, w_sipo_shift;
  logic              w_piso_sout;
  logic [PW-1:0]     w_piso_q_unused;
  logic [DATA_W-1:0] w_sipo_q;
  logic              w_sipo_sout_unused;
  logic              w_to_done, w_to_err;

  // Transmit order is slave id, then address, then write data, each LSB first.
  bus_shift_reg #(.W(PW)) u_piso (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .i_load     (w_piso_load),
    .i_load_dat ({M_WDATA, M_ADDR, M_SLAVE}),
    .i_shift    (w_piso_shift),
    .i_sin      (1'b0),
    .o_q        (w_piso_q_unused),
    .o_sout     (w_piso_sout)
  );

  bus_shift_reg #(.W(DATA_W)) u_sipo (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .i_load     (1'b0),
    .i_load_dat ('0),
    .i_shift    (w_sipo_shift),
    .i_sin      (B_RDATA),
    .o_q        (w_sipo_q),
    .o_sout     (w_sipo_sout_unused)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rw    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_req   <= 1'b0;
      r_util  <= 1'b0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_wbit  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_rw    <= w_rw;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
      r_rdata <= w_rdata;
      r_req   <= w_req;
      r_util  <= w_util;
      r_mode  <= w_mode;
      r_valid <= w_valid;
      r_wbit  <= w_wbit;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_rw         = r_rw;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_err        = r_err;
    w_rdata      = r_rdata;
    w_req        = r_req;
    w_util       = r_util;
    w_mode       = r_mode;
    w_valid      = 1'b0;
    w_wbit       = 1'b0;
    w_piso_load  = 1'b0;
    w_piso_shift = 1'b0;
    w_sipo_shift = 1'b0;
    w_to_done    = 1'b0;
    w_to_err     = 1'b0;

    case (r_state)
      IDLE: begin
        if (M_START) begin
          w_piso_load = 1'b1;
          w_rw        = M_RW;
          w_busy      = 1'b1;
          w_req       = 1'b1;
          w_err       = 1'b0;
          w_cnt       = '0;
          w_state     = REQ;
        end
      end
      REQ: begin
        if (B_GRANT) begin
          w_util       = 1'b1;
          w_mode       = r_rw;
          w_valid      = 1'b1;
          w_wbit       = w_piso_sout;
          w_piso_shift = 1'b1;
          w_cnt        = '0;
          w_state      = ADDR;
        end
      end
      ADDR: begin
        if (!B_GRANT) begin
          w_to_done = 1'b1;
          w_to_err  = 1'b1;
        end else if (r_cnt == CNT_W'(AW - 1)) begin
          // Count starts at 1 so the timeout lands ACK_TIMEOUT cycles after the last address bit.
          w_cnt   = CNT_W'(1);
          w_state = ACK_WAIT;
        end else begin
          w_valid      = 1'b1;
          w_wbit       = w_piso_sout;
          w_piso_shift = 1'b1;
          w_cnt        = r_cnt + CNT_W'(1);
        end
      end
      ACK_WAIT: begin
        if (!B_GRANT) begin
          w_to_done = 1'b1;
          w_to_err  = 1'b1;
        end else if (B_ACK) begin
          w_cnt = '0;
          if (r_rw) begin
            w_valid      = 1'b1;
            w_wbit       = w_piso_sout;
            w_piso_shift = 1'b1;
            w_state      = WDATA;
          end else begin
            w_state = RWAIT;
          end
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_to_done = 1'b1;
          w_to_err  = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      WDATA: begin
        if (!B_GRANT) begin
          w_to_done = 1'b1;
          w_to_err  = 1'b1;
        end else if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_to_done = 1'b1;
        end else begin
          w_valid      = 1'b1;
          w_wbit       = w_piso_sout;
          w_piso_shift = 1'b1;
          w_cnt        = r_cnt + CNT_W'(1);
        end
      end
      RWAIT, RDATA: begin
        // A read bit takes priority over a split arriving in the same cycle.
        if (!B_GRANT && !B_SPLIT) begin
          w_to_done = 1'b1;
          w_to_err  = 1'b1;
        end else if (B_RVALID) begin
          w_sipo_shift = 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            w_rdata   = DATA_W'({B_RDATA, w_sipo_q} >> 1);
            w_to_done = 1'b1;
          end else begin
            w_cnt   = r_cnt + CNT_W'(1);
            w_state = RDATA;
          end
        end else if (B_SPLIT) begin
          w_util  = 1'b0;
          w_mode  = 1'b0;
          w_state = SPLIT_WAIT;
        end
      end
      SPLIT_WAIT: begin
        if (B_SPL_RESUME && B_GRANT) begin
          w_util  = 1'b1;
          w_mode  = r_rw;
          w_state = (r_cnt == '0) ? RWAIT : RDATA;
        end
      end
      DONE: begin
        w_busy  = 1'b0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase

    if (w_to_done) begin
      w_state = DONE;
      w_done  = 1'b1;
      w_err   = w_to_err;
      w_req   = 1'b0;
      w_util  = 1'b0;
      w_mode  = 1'b0;
      w_valid = 1'b0;
      w_wbit  = 1'b0;
    end
  end

  assign M_BUSY  = r_busy;
  assign M_DONE  = r_done;
  assign M_ERR   = r_err;
  assign M_RDATA = r_rdata;
  assign B_REQ   = r_req;
  assign B_UTIL  = r_util;
  assign B_MODE  = r_mode;
  assign B_VALID = r_valid;
  assign B_WDATA = r_wbit;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: write, read, ACK timeout, split/resume,
// grant loss, ignored start while busy and asynchronous reset mid-transfer.
module tb_bus_master_port;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        M_START, M_RW;
  logic [1:0]  M_SLAVE;
  logic [11:0] M_ADDR;
  logic [7:0]  M_WDATA;
  logic        M_BUSY, M_DONE, M_ERR;
  logic [7:0]  M_RDATA;
  logic        B_REQ, B_GRANT, B_UTIL, B_MODE, B_VALID, B_WDATA;
  logic        B_ACK, B_RVALID, B_RDATA, B_SPLIT, B_SPL_RESUME;

  int n_tests = 0;
  int n_fail  = 0;

  bus_master_port dut (
    .CLK(CLK), .RSTN(RSTN),
    .M_START(M_START), .M_RW(M_RW), .M_SLAVE(M_SLAVE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_BUSY(M_BUSY), .M_DONE(M_DONE), .M_ERR(M_ERR), .M_RDATA(M_RDATA),
    .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_UTIL(B_UTIL), .B_MODE(B_MODE),
    .B_VALID(B_VALID), .B_WDATA(B_WDATA), .B_ACK(B_ACK), .B_RVALID(B_RVALID),
    .B_RDATA(B_RDATA), .B_SPLIT(B_SPLIT), .B_SPL_RESUME(B_SPL_RESUME)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture a contiguous B_VALID burst, waiting a bounded time for it to start.
  task automatic get_serial(output logic [31:0] w, output int n, output logic m_or, output logic m_and);
    w = '0; n = 0; m_or = 1'b0; m_and = 1'b1;
    for (int t = 0; t < 20 && !B_VALID; t++) step();
    while (B_VALID && n < 32) begin
      w[n]  = B_WDATA;
      m_or  = m_or | B_MODE;
      m_and = m_and & B_MODE;
      n++;
      step();
    end
  endtask

  task automatic start_cmd(input logic rw, input logic [1:0] sid, input logic [11:0] addr, input logic [7:0] wd);
    M_START = 1'b1; M_RW = rw; M_SLAVE = sid; M_ADDR = addr; M_WDATA = wd;
    step();
    M_START = 1'b0;
  endtask

  logic [31:0] w;
  int          n, k;
  logic        m_or, m_and, flag;
  logic [7:0]  rd;

  initial begin
    RSTN = 1'b0; M_START = 1'b0; M_RW = 1'b0; M_SLAVE = '0; M_ADDR = '0; M_WDATA = '0;
    B_GRANT = 1'b0; B_ACK = 1'b0; B_RVALID = 1'b0; B_RDATA = 1'b0; B_SPLIT = 1'b0; B_SPL_RESUME = 1'b0;
    step(); step();
    chk("reset_outs", {M_BUSY, M_DONE, M_ERR, B_REQ, B_UTIL, B_MODE, B_VALID, B_WDATA}, 32'h0);
    chk("reset_rdata", M_RDATA, 32'h0);
    RSTN = 1'b1;
    step();

    // 1: write slave 1, addr 0x0A5, data 0x3C; grant at cycle 3, ACK on 2nd wait cycle
    start_cmd(1'b1, 2'd1, 12'h0A5, 8'h3C);
    chk("t1_req", {M_BUSY, B_REQ, B_UTIL}, 32'b110);
    step(); step();
    B_GRANT = 1'b1;
    step();
    get_serial(w, n, m_or, m_and);
    chk("t1_addr_len", n, 14);
    chk("t1_addr_bits", w, 32'h295);
    chk("t1_mode", m_and, 1'b1);
    step();
    B_ACK = 1'b1;
    step();
    B_ACK = 1'b0;
    get_serial(w, n, m_or, m_and);
    chk("t1_data_len", n, 8);
    chk("t1_data_bits", w, 32'h3C);
    chk("t1_done", {M_DONE, M_ERR, M_BUSY, B_REQ, B_UTIL, B_VALID}, 32'b101000);
    chk("t1_rdata_kept", M_RDATA, 32'h0);
    B_GRANT = 1'b0;
    step();
    chk("t1_idle", {M_DONE, M_BUSY}, 32'b00);

    // 2: read slave 2, addr 0x123; data 0xA7 after 5 RWAIT cycles
    start_cmd(1'b0, 2'd2, 12'h123, 8'hFF);
    B_GRANT = 1'b1;
    step();
    get_serial(w, n, m_or, m_and);
    chk("t2_addr_len", n, 14);
    chk("t2_addr_bits", w, 32'h48E);
    B_ACK = 1'b1;
    step();
    B_ACK = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (B_MODE !== 1'b0 || B_UTIL !== 1'b1) flag = 1'b1;
      step();
    end
    rd = 8'hA7;
    for (int i = 0; i < 8; i++) begin
      if (B_MODE !== 1'b0 || B_UTIL !== 1'b1) flag = 1'b1;
      B_RVALID = 1'b1; B_RDATA = rd[i];
      step();
    end
    B_RVALID = 1'b0; B_RDATA = 1'b0;
    chk("t2_mode_util", {m_or, flag}, 32'b00);
    chk("t2_done", {M_DONE, M_ERR, B_UTIL}, 32'b100);
    chk("t2_rdata", M_RDATA, 32'hA7);
    B_GRANT = 1'b0;
    step();

    // 3: no ACK -> timeout 8 cycles after the last address bit
    start_cmd(1'b1, 2'd3, 12'hFFF, 8'h55);
    B_GRANT = 1'b1;
    step();
    get_serial(w, n, m_or, m_and);
    chk("t3_addr_len", n, 14);
    k = 1;
    while (k < 20 && !M_DONE) begin
      step();
      k++;
    end
    chk("t3_timeout_cycles", k, 8);
    chk("t3_err", {M_DONE, M_ERR, B_REQ, B_UTIL}, 32'b1100);
    chk("t3_rdata_kept", M_RDATA, 32'hA7);
    B_GRANT = 1'b0;
    step();

    // 4: read with split after 3 bits, resume 20 cycles later; data 0x5A
    rd = 8'h5A;
    start_cmd(1'b0, 2'd0, 12'h040, 8'h00);
    B_GRANT = 1'b1;
    step();
    get_serial(w, n, m_or, m_and);
    B_ACK = 1'b1;
    step();
    B_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      B_RVALID = 1'b1; B_RDATA = rd[i]; B_SPLIT = (i == 1);
      step();
    end
    chk("t4_split_vs_rvalid", B_UTIL, 1'b1);
    B_RVALID = 1'b0; B_SPLIT = 1'b1; B_GRANT = 1'b0;
    step();
    B_SPLIT = 1'b0;
    chk("t4_split", {B_UTIL, B_REQ, M_BUSY}, 32'b011);
    flag = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (B_UTIL !== 1'b0 || B_REQ !== 1'b1 || M_DONE !== 1'b0) flag = 1'b1;
    end
    chk("t4_split_hold", flag, 1'b0);
    B_SPL_RESUME = 1'b1; B_GRANT = 1'b1;
    step();
    B_SPL_RESUME = 1'b0;
    chk("t4_resume", B_UTIL, 1'b1);
    for (int i = 3; i < 8; i++) begin
      if (i == 5) begin
        B_RVALID = 1'b0;
        step();
      end
      B_RVALID = 1'b1; B_RDATA = rd[i];
      step();
    end
    B_RVALID = 1'b0; B_RDATA = 1'b0;
    chk("t4_done", {M_DONE, M_ERR}, 32'b10);
    chk("t4_rdata", M_RDATA, 32'h5A);
    B_GRANT = 1'b0;
    step();

    // 5a: grant withdrawn at address bit 6; start while busy is ignored
    start_cmd(1'b1, 2'd1, 12'h0A5, 8'h3C);
    B_GRANT = 1'b1;
    step();
    for (int i = 0; i < 6; i++) step();
    B_GRANT = 1'b0;
    M_START = 1'b1;
    step();
    M_START = 1'b0;
    chk("t5_gloss", {M_DONE, M_ERR, B_UTIL, B_VALID}, 32'b1100);
    step();
    chk("t5_ignored_start", {M_BUSY, B_REQ}, 32'b00);
    step();
    chk("t5_still_idle", {M_BUSY, B_REQ}, 32'b00);

    // 5b: asynchronous reset during WDATA
    start_cmd(1'b1, 2'd1, 12'h0A5, 8'h3C);
    B_GRANT = 1'b1;
    step();
    get_serial(w, n, m_or, m_and);
    B_ACK = 1'b1;
    step();
    B_ACK = 1'b0;
    step();
    chk("t5_in_wdata", {B_VALID, B_UTIL}, 32'b11);
    #2 RSTN = 1'b0;
    #1;
    chk("t5_async_rst", {M_BUSY, M_DONE, M_ERR, B_REQ, B_UTIL, B_MODE, B_VALID, B_WDATA}, 32'h0);
    chk("t5_rst_rdata", M_RDATA, 32'h0);
    step();
    #2 RSTN = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (M_DONE !== 1'b0 || M_BUSY !== 1'b0) flag = 1'b1;
    end
    chk("t5_no_done", flag, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
